// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive framer: FSM state encoding, parity
// selectors, minimum oversampling ratio and the 3-input majority helper.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   PRESCALE_MIN = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line, frame configuration and received-byte/status bundle of the UART RX framer.
// master = upstream line/config driver, slave = the framer itself.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);

  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  rx_busy;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err, rx_busy
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err, rx_busy
  );

endinterface

// File: rtl/uart_rx_frame_sampler.sv
// Per-bit oversampling counter with three-point majority sampling around the
// bit centre; reports the voted bit, its decision strobe and end-of-bit.
module uart_rx_frame_sampler
  import uart_rx_frame_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rx_bit,
  output logic                  sample_stb,
  output logic                  bit_end
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic                  s0;
  logic                  s1;

  assign half       = prescale >> 1;
  assign bit_end    = (edge_cnt == (prescale - ONE));
  assign sample_stb = (edge_cnt == (half + ONE));
  // third vote is the live line value in the decision cycle itself
  assign rx_bit     = maj3(s0, s1, rx_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      if (!run || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + ONE;
      end
      if (edge_cnt == (half - ONE)) begin
        s0 <= rx_in;
      end
      if (edge_cnt == half) begin
        s1 <= rx_in;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, LSB-first deserialisation, optional even/odd
// parity and stop-bit check, one-cycle valid/error strobes per completed frame.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_frame_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(PRESCALE_MIN);

  rx_state_t state;
  rx_state_t state_nxt;

  logic                  armed;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad;
  logic                  exp_par;

  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic rx_bit;
  logic sample_stb;
  logic bit_end;

  logic capture;
  logic run;
  logic shift_en;
  logic bit_adv;
  logic par_chk;
  logic stop_chk;
  logic rx_busy;

  uart_rx_frame_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .rx_in      (bus.rx_in),
    .prescale   (prescale_q),
    .rx_bit     (rx_bit),
    .sample_stb (sample_stb),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (armed && !bus.rx_in) state_nxt = ST_START;
      end
      ST_START: begin
        if (sample_stb && rx_bit) state_nxt = ST_IDLE;
        else if (bit_end)         state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (sample_stb) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == ST_IDLE) && (state_nxt == ST_START);
    // the bit counter must restart on the very cycle the frame ends or aborts
    run      = (state_nxt != ST_IDLE);
    shift_en = (state == ST_DATA)   && sample_stb;
    bit_adv  = (state == ST_DATA)   && bit_end;
    par_chk  = (state == ST_PARITY) && sample_stb;
    stop_chk = (state == ST_STOP)   && sample_stb;
    rx_busy  = (state != ST_IDLE);
  end

  assign exp_par = (par_typ_q == PAR_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      prescale_q <= P_MIN;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      armed     <= armed | bus.rx_in;

      if (capture) begin
        prescale_q <= (bus.prescale < P_MIN) ? P_MIN : bus.prescale;
        par_en_q   <= bus.par_en;
        par_typ_q  <= bus.par_typ;
        bit_cnt    <= '0;
        par_bad    <= 1'b0;
      end

      if (shift_en) begin
        shreg <= {rx_bit, shreg[DATA_WIDTH-1:1]};
      end

      if (bit_adv) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end

      if (par_chk) begin
        par_bad <= (rx_bit != exp_par);
      end

      if (stop_chk) begin
        if (rx_bit && !par_bad) begin
          p_data_q <= shreg;
          valid_q  <= 1'b1;
        end else begin
          par_err_q <= par_bad;
          stp_err_q <= ~rx_bit;
        end
      end
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.rx_busy    = rx_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frames against a frame-level reference model of the
// UART RX framer (expected outcome, retained byte and strobe timing).
module tb_uart_rx_frame;

  localparam int DW = 8;
  localparam int PW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int edges    = 0;
  int vld_cnt  = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;
  int ovl_cnt  = 0;
  int vld_edge = 0;
  logic [DW-1:0] vq[$];

  int b_v, b_p, b_s;
  logic [DW-1:0] exp_last = '0;
  int  exp_edge;
  bit  ev, ep, es;

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      vld_cnt++;
      vld_edge = edges;
      vq.push_back(bus.p_data);
    end
    if (bus.par_err) perr_cnt++;
    if (bus.stp_err) serr_cnt++;
    if (bus.data_valid && (bus.par_err || bus.stp_err)) ovl_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic mark();
    b_v = vld_cnt;
    b_p = perr_cnt;
    b_s = serr_cnt;
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame and updates the model's expected outcome.
  task automatic send_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit corrupt_par, input bit stop, input int p,
                            input int idle);
    int  ones;
    bit  pbit;
    logic [DW-1:0] dv;
    dv           = d;
    bus.prescale = PW'(p);
    bus.par_en   = pe;
    bus.par_typ  = pt;
    exp_edge     = edges + 1 + (1 + DW + (pe ? 1 : 0)) * p + p / 2 + 1;
    hold(1'b0, p);
    for (int i = 0; i < DW; i++) hold(dv[i], p);
    if (pe) begin
      ones = $countones(d);
      pbit = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      hold(pbit ^ corrupt_par, p);
    end
    if (stop) begin
      hold(1'b1, p);
    end else begin
      hold(1'b0, p / 2 + 2);
      hold(1'b1, p - (p / 2 + 2));
    end
    if (idle > 0) hold(1'b1, idle);
    ep = pe && corrupt_par;
    es = !stop;
    ev = !ep && !es;
    if (ev) exp_last = d;
  endtask

  task automatic expect_frame(input string tag, input bit check_lat);
    logic [DW-1:0] got;
    chk({tag, ".valid_cnt"}, 32'(vld_cnt - b_v), 32'(ev));
    chk({tag, ".par_err_cnt"}, 32'(perr_cnt - b_p), 32'(ep));
    chk({tag, ".stp_err_cnt"}, 32'(serr_cnt - b_s), 32'(es));
    chk({tag, ".p_data"}, 32'(bus.p_data), 32'(exp_last));
    chk({tag, ".rx_busy"}, 32'(bus.rx_busy), 32'd0);
    chk({tag, ".overlap"}, 32'(ovl_cnt), 32'd0);
    if (ev) begin
      got = (vq.size() > 0) ? vq.pop_front() : 'x;
      chk({tag, ".strobe_byte"}, 32'(got), 32'(exp_last));
      if (check_lat) chk({tag, ".strobe_edge"}, 32'(vld_edge), 32'(exp_edge));
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit rpe, rpt, rbad, rstop;
    int rp, ridle;

    bus.rx_in    = 1'b0;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.prescale = PW'(8);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.p_data", 32'(bus.p_data), 32'd0);
    chk("rst.data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst.par_err", 32'(bus.par_err), 32'd0);
    chk("rst.stp_err", 32'(bus.stp_err), 32'd0);
    chk("rst.rx_busy", 32'(bus.rx_busy), 32'd0);

    // line low out of reset: not armed, no start accepted
    rst_n = 1'b1;
    mark();
    hold(1'b0, 20);
    chk("arm.rx_busy", 32'(bus.rx_busy), 32'd0);
    chk("arm.no_strobe", 32'(vld_cnt - b_v + perr_cnt - b_p + serr_cnt - b_s), 32'd0);
    hold(1'b1, 2);

    // 1: P=8, no parity, 0xA5
    mark();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2);
    expect_frame("t1", 1'b1);

    // 2: P=16, even parity, 0x37 good then bad parity
    mark();
    send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 16, 2);
    expect_frame("t2a", 1'b1);
    mark();
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 16, 2);
    expect_frame("t2b", 1'b0);

    // 3: P=32, odd parity, 0x00, stop low then good
    mark();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32, 4);
    expect_frame("t3a", 1'b0);
    mark();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32, 2);
    expect_frame("t3b", 1'b1);

    // 4: 3-cycle glitch at P=16 rejected, then 0x5A
    mark();
    bus.prescale = PW'(16);
    bus.par_en   = 1'b0;
    hold(1'b0, 3);
    chk("t4.busy_during", 32'(bus.rx_busy), 32'd1);
    hold(1'b1, 32);
    chk("t4.busy_after", 32'(bus.rx_busy), 32'd0);
    chk("t4.no_strobe", 32'(vld_cnt - b_v + perr_cnt - b_p + serr_cnt - b_s), 32'd0);
    mark();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16, 2);
    expect_frame("t4", 1'b1);

    // 5: back-to-back 0x11, 0xEE at P=8 with no idle gap
    mark();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8, 0);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2);
    chk("t5.valid_cnt", 32'(vld_cnt - b_v), 32'd2);
    chk("t5.err_cnt", 32'(perr_cnt - b_p + serr_cnt - b_s), 32'd0);
    chk("t5.byte0", 32'((vq.size() > 0) ? vq.pop_front() : 8'hxx), 32'h11);
    chk("t5.byte1", 32'((vq.size() > 0) ? vq.pop_front() : 8'hxx), 32'hEE);
    chk("t5.edge1", 32'(vld_edge), 32'(exp_edge));
    chk("t5.p_data", 32'(bus.p_data), 32'hEE);

    // randomized frames
    for (int k = 0; k < 12; k++) begin
      rd    = DW'($urandom_range(0, 255));
      rpe   = 1'($urandom_range(0, 1));
      rpt   = 1'($urandom_range(0, 1));
      rbad  = rpe && ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) != 0);
      rp    = 8 << $urandom_range(0, 2);
      ridle = $urandom_range(0, 3);
      mark();
      send_frame(rd, rpe, rpt, rbad, rstop, rp, ridle);
      expect_frame($sformatf("rnd%0d", k), 1'b1);
    end

    // 6: reset mid-DATA with line low, no false frame afterwards
    mark();
    bus.prescale = PW'(16);
    bus.par_en   = 1'b0;
    hold(1'b0, 16 + 2 * 16 + 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_last = '0;
    chk("t6.rst_p_data", 32'(bus.p_data), 32'd0);
    chk("t6.rst_busy", 32'(bus.rx_busy), 32'd0);
    rst_n = 1'b1;
    hold(1'b0, 48);
    chk("t6.busy_low", 32'(bus.rx_busy), 32'd0);
    chk("t6.no_strobe", 32'(vld_cnt - b_v + perr_cnt - b_p + serr_cnt - b_s), 32'd0);
    hold(1'b1, 2);
    mark();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 16, 2);
    expect_frame("t6", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
